// File: rtl/ppg_pkg.sv
// ppg_pkg: shared widths and one-hot state encoding for the PPG front-end sequencer
package ppg_pkg;

    localparam int DC_W  = 7;
    localparam int PGA_W = 4;
    localparam int ADC_W = 8;

    typedef enum logic [7:0] {
        IDLE        = 8'b0000_0001,
        RED_SETTLE  = 8'b0000_0010,
        RED_ACQ     = 8'b0000_0100,
        IR_SETTLE   = 8'b0000_1000,
        IR_ACQ      = 8'b0001_0000,
        DARK_SETTLE = 8'b0010_0000,
        DARK_ACQ    = 8'b0100_0000,
        DONE        = 8'b1000_0000
    } state_t;

endpackage

// File: rtl/ppg_phase_accumulator.sv
// ppg_phase_accumulator: sums ADC samples over one phase; avg includes the current sample
module ppg_phase_accumulator
    import ppg_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [ADC_W-1:0] sample,
    output logic [ADC_W-1:0] avg
);

    localparam int ACC_W = ADC_W + AVG_LOG2;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    assign sum = acc + ACC_W'(sample);
    assign avg = ADC_W'(sum >> AVG_LOG2);

    // running sum, cleared while the phase is settling
    always_ff @(posedge CLK or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= sum;
    end

endmodule

// File: rtl/ppg_channel_sequencer.sv
// ppg_channel_sequencer: time-multiplexes the analog front-end across RED/IR/DARK phases
module ppg_channel_sequencer
    import ppg_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int AVG_LOG2   = 3,
    parameter bit DARK_EN    = 1'b1
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_load,
    input  logic [DC_W-1:0]  cfg_red_dc,
    input  logic [PGA_W-1:0] cfg_red_pga,
    input  logic [DC_W-1:0]  cfg_ir_dc,
    input  logic [PGA_W-1:0] cfg_ir_pga,
    input  logic [ADC_W-1:0] ADC,
    output logic             LED_RED,
    output logic             LED_IR,
    output logic [DC_W-1:0]  DC_Comp,
    output logic [PGA_W-1:0] PGA_Gain,
    output logic [ADC_W-1:0] RED_ADC_Value,
    output logic [ADC_W-1:0] IR_ADC_Value,
    output logic [ADC_W-1:0] DARK_ADC_Value,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic             overrun
);

    localparam int ACQ_CYC = 1 << AVG_LOG2;
    localparam int CNT_W   = $clog2(SETTLE_CYC + ACQ_CYC) + 1;

    state_t           st, nxt;
    logic [CNT_W-1:0] cnt;
    logic             settling, acquiring, last;
    logic             enter_red, enter_ir, enter_dark;
    logic [DC_W-1:0]  pend_red_dc, pend_ir_dc, act_red_dc, act_ir_dc;
    logic [PGA_W-1:0] pend_red_pga, pend_ir_pga, act_red_pga, act_ir_pga;
    logic [ADC_W-1:0] avg, stg_red, stg_ir, stg_dark;

    assign settling   = st inside {RED_SETTLE, IR_SETTLE, DARK_SETTLE};
    assign acquiring  = st inside {RED_ACQ, IR_ACQ, DARK_ACQ};
    assign last       = settling ? (cnt == CNT_W'(SETTLE_CYC - 1)) : (cnt == CNT_W'(ACQ_CYC - 1));
    assign enter_red  = (nxt == RED_SETTLE) && (st != RED_SETTLE);
    assign enter_ir   = (nxt == IR_SETTLE) && (st != IR_SETTLE);
    assign enter_dark = (nxt == DARK_SETTLE) && (st != DARK_SETTLE);

    // next-state: phases advance when their cycle budget runs out
    always_comb begin
        nxt = st;
        case (st)
            IDLE:        nxt = enable ? RED_SETTLE : IDLE;
            RED_SETTLE:  nxt = last ? RED_ACQ : st;
            RED_ACQ:     nxt = last ? IR_SETTLE : st;
            IR_SETTLE:   nxt = last ? IR_ACQ : st;
            IR_ACQ:      nxt = last ? (DARK_EN ? DARK_SETTLE : DONE) : st;
            DARK_SETTLE: nxt = last ? DARK_ACQ : st;
            DARK_ACQ:    nxt = last ? DONE : st;
            DONE:        nxt = enable ? RED_SETTLE : IDLE;
            default:     nxt = IDLE;
        endcase
    end

    // state register and per-phase cycle counter, restarted on every transition
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            st  <= IDLE;
            cnt <= '0;
        end else begin
            st  <= nxt;
            cnt <= (nxt != st) ? '0 : cnt + CNT_W'(1);
        end
    end

    // pending config follows cfg_load; active config is frozen at frame start
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            pend_red_dc  <= '0;
            pend_red_pga <= '0;
            pend_ir_dc   <= '0;
            pend_ir_pga  <= '0;
            act_red_dc   <= '0;
            act_red_pga  <= '0;
            act_ir_dc    <= '0;
            act_ir_pga   <= '0;
        end else begin
            if (cfg_load) begin
                pend_red_dc  <= cfg_red_dc;
                pend_red_pga <= cfg_red_pga;
                pend_ir_dc   <= cfg_ir_dc;
                pend_ir_pga  <= cfg_ir_pga;
            end
            if (enter_red) begin
                act_red_dc  <= pend_red_dc;
                act_red_pga <= pend_red_pga;
                act_ir_dc   <= pend_ir_dc;
                act_ir_pga  <= pend_ir_pga;
            end
        end
    end

    // front-end controls switch on the edge entering each settle window
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            LED_RED  <= 1'b0;
            LED_IR   <= 1'b0;
            DC_Comp  <= '0;
            PGA_Gain <= '0;
        end else begin
            LED_RED <= nxt inside {RED_SETTLE, RED_ACQ};
            LED_IR  <= nxt inside {IR_SETTLE, IR_ACQ};
            if (enter_red) begin
                DC_Comp  <= pend_red_dc;
                PGA_Gain <= pend_red_pga;
            end else if (enter_ir) begin
                DC_Comp  <= act_ir_dc;
                PGA_Gain <= act_ir_pga;
            end else if (enter_dark) begin
                DC_Comp  <= act_red_dc;
                PGA_Gain <= act_red_pga;
            end
        end
    end

    // capture each phase average on its final acquisition cycle
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            stg_red  <= '0;
            stg_ir   <= '0;
            stg_dark <= '0;
        end else if (acquiring && last) begin
            if (st == RED_ACQ)  stg_red  <= avg;
            if (st == IR_ACQ)   stg_ir   <= avg;
            if (st == DARK_ACQ) stg_dark <= avg;
        end
    end

    // publish results; a fresh frame always wins over a pending handshake
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            RED_ADC_Value  <= '0;
            IR_ADC_Value   <= '0;
            DARK_ADC_Value <= '0;
            frame_valid    <= 1'b0;
            overrun        <= 1'b0;
        end else if (st == DONE) begin
            RED_ADC_Value  <= stg_red;
            IR_ADC_Value   <= stg_ir;
            DARK_ADC_Value <= stg_dark;
            frame_valid    <= 1'b1;
            overrun        <= overrun | (frame_valid & ~frame_ready);
        end else begin
            if (frame_ready) frame_valid <= 1'b0;
            if (st == IDLE && !enable) overrun <= 1'b0;
        end
    end

    ppg_phase_accumulator #(.AVG_LOG2(AVG_LOG2)) u_acc (
        .CLK    (CLK),
        .rst    (rst),
        .clr    (settling),
        .en     (acquiring),
        .sample (ADC),
        .avg    (avg)
    );

endmodule

// File: tb/tb_ppg_channel_sequencer.sv
// tb_ppg_channel_sequencer: directed frames with a scoreboard of expected phase averages
module tb_ppg_channel_sequencer;

    localparam int FL = 37;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] i;
        logic [7:0] d;
    } frm_t;

    logic       CLK = 1'b0, rst = 1'b1, enable = 1'b0, cfg_load = 1'b0, frame_ready = 1'b0;
    logic [6:0] cfg_red_dc = '0, cfg_ir_dc = '0;
    logic [3:0] cfg_red_pga = '0, cfg_ir_pga = '0;
    logic [7:0] ADC = '0;
    logic       LED_RED, LED_IR, frame_valid, overrun;
    logic [6:0] DC_Comp;
    logic [3:0] PGA_Gain;
    logic [7:0] RED_ADC_Value, IR_ADC_Value, DARK_ADC_Value;

    logic       en0 = 1'b0, rdy0 = 1'b0;
    logic [7:0] adc0 = 8'd77;
    logic       l0r, l0i, fv0, ov0;
    logic [6:0] dc0;
    logic [3:0] pga0;
    logic [7:0] r0, i0, d0;

    logic [7:0] pr [8];
    logic [7:0] pi [8];
    logic [7:0] pd [8];
    frm_t       q[$];
    int         total = 0, bad = 0;
    logic [6:0] p_rdc = '0, p_idc = '0, a_rdc = '0, a_idc = '0;
    logic [3:0] p_rpga = '0, p_ipga = '0, a_rpga = '0, a_ipga = '0;
    logic       exp_fv = 1'b0, exp_ovr = 1'b0;

    always #5 CLK = ~CLK;

    ppg_channel_sequencer dut (
        .CLK(CLK), .rst(rst), .enable(enable), .cfg_load(cfg_load),
        .cfg_red_dc(cfg_red_dc), .cfg_red_pga(cfg_red_pga),
        .cfg_ir_dc(cfg_ir_dc), .cfg_ir_pga(cfg_ir_pga), .ADC(ADC),
        .LED_RED(LED_RED), .LED_IR(LED_IR), .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain),
        .RED_ADC_Value(RED_ADC_Value), .IR_ADC_Value(IR_ADC_Value),
        .DARK_ADC_Value(DARK_ADC_Value), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .overrun(overrun)
    );

    ppg_channel_sequencer #(.DARK_EN(1'b0)) dut0 (
        .CLK(CLK), .rst(rst), .enable(en0), .cfg_load(cfg_load),
        .cfg_red_dc(cfg_red_dc), .cfg_red_pga(cfg_red_pga),
        .cfg_ir_dc(cfg_ir_dc), .cfg_ir_pga(cfg_ir_pga), .ADC(adc0),
        .LED_RED(l0r), .LED_IR(l0i), .DC_Comp(dc0), .PGA_Gain(pga0),
        .RED_ADC_Value(r0), .IR_ADC_Value(i0), .DARK_ADC_Value(d0),
        .frame_valid(fv0), .frame_ready(rdy0), .overrun(ov0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pop_chk(input string tag);
        frm_t e;
        chk({tag, "_sb_nonempty"}, 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_red"}, RED_ADC_Value, e.r);
            chk({tag, "_ir"}, IR_ADC_Value, e.i);
            chk({tag, "_dark"}, DARK_ADC_Value, e.d);
        end
    endtask

    // called one cycle after the edge that entered RED_SETTLE
    task automatic run_frame(input string tag, input int drop_k, input int load_k, input int rdy_k);
        int   sr, si, sd;
        frm_t e;
        sr = 0; si = 0; sd = 0;
        for (int j = 0; j < 8; j++) begin
            sr += int'(pr[j]);
            si += int'(pi[j]);
            sd += int'(pd[j]);
        end
        e.r = 8'(sr >> 3);
        e.i = 8'(si >> 3);
        e.d = 8'(sd >> 3);
        q.push_back(e);
        a_rdc = p_rdc; a_rpga = p_rpga; a_idc = p_idc; a_ipga = p_ipga;
        for (int k = 0; k < FL; k++) begin
            if (k >= 4 && k < 12)       ADC = pr[k-4];
            else if (k >= 16 && k < 24) ADC = pi[k-16];
            else if (k >= 28 && k < 36) ADC = pd[k-28];
            else                        ADC = 8'($urandom);
            if (k == 0) begin
                chk({tag, "_red_led"}, {LED_RED, LED_IR}, 2'b10);
                chk({tag, "_red_dc"}, DC_Comp, a_rdc);
                chk({tag, "_red_pga"}, PGA_Gain, a_rpga);
            end
            if (k == 12) begin
                chk({tag, "_ir_led"}, {LED_RED, LED_IR}, 2'b01);
                chk({tag, "_ir_dc"}, DC_Comp, a_idc);
                chk({tag, "_ir_pga"}, PGA_Gain, a_ipga);
            end
            if (k == 24) begin
                chk({tag, "_dark_led"}, {LED_RED, LED_IR}, 2'b00);
                chk({tag, "_dark_dc"}, DC_Comp, a_rdc);
                chk({tag, "_dark_pga"}, PGA_Gain, a_rpga);
            end
            if (k == FL - 1) chk({tag, "_valid_before_done"}, frame_valid, exp_fv);
            if (k == drop_k) enable = 1'b0;
            if (k == load_k) begin
                cfg_red_dc = 7'd50;
                cfg_load = 1'b1;
                p_rdc = 7'd50;
            end
            if (k == rdy_k) frame_ready = 1'b1;
            if (rdy_k >= 0 && k == rdy_k + 1) begin
                frame_ready = 1'b0;
                exp_fv = 1'b0;
                chk({tag, "_valid_cleared"}, frame_valid, 0);
                chk({tag, "_ovr_after_ready"}, overrun, exp_ovr);
            end
            step(1);
            if (k == load_k) cfg_load = 1'b0;
        end
        if (exp_fv) exp_ovr = 1'b1;
        exp_fv = 1'b1;
        chk({tag, "_valid"}, frame_valid, 1);
        chk({tag, "_overrun"}, overrun, exp_ovr);
        pop_chk(tag);
    endtask

    initial begin
        int n;
        step(2);
        chk("rst_led", {LED_RED, LED_IR}, 0);
        chk("rst_dc_pga", {DC_Comp, PGA_Gain}, 0);
        chk("rst_values", {RED_ADC_Value, IR_ADC_Value, DARK_ADC_Value}, 0);
        chk("rst_valid_ovr", {frame_valid, overrun}, 0);
        rst = 1'b0;
        cfg_red_dc = 7'd20; cfg_red_pga = 4'd5; cfg_ir_dc = 7'd40; cfg_ir_pga = 4'd7; cfg_load = 1'b1;
        p_rdc = 7'd20; p_rpga = 4'd5; p_idc = 7'd40; p_ipga = 4'd7;
        step(1);
        cfg_load = 1'b0;
        chk("idle_dc_hold", DC_Comp, 0);
        chk("idle_led_off", {LED_RED, LED_IR}, 0);
        enable = 1'b1;
        step(1);

        for (int j = 0; j < 8; j++) begin pr[j] = 8'd100; pi[j] = 8'd200; pd[j] = 8'd20; end
        run_frame("f1", -1, 18, -1);

        for (int j = 0; j < 8; j++) begin pr[j] = 8'(100 + j % 2); pi[j] = 8'd255; pd[j] = 8'(j); end
        run_frame("f2", -1, -1, -1);

        for (int j = 0; j < 8; j++) begin pr[j] = 8'($urandom); pi[j] = 8'($urandom); pd[j] = 8'($urandom); end
        run_frame("f3", 6, -1, 5);
        chk("f3_idle_led", {LED_RED, LED_IR}, 0);
        step(1);
        exp_ovr = 1'b0;
        chk("ovr_clear_idle", overrun, 0);

        enable = 1'b1;
        step(14);
        chk("pre_rst_ir_led", {LED_RED, LED_IR}, 2'b01);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_led", {LED_RED, LED_IR}, 0);
        chk("async_rst_dc_pga", {DC_Comp, PGA_Gain}, 0);
        chk("async_rst_valid", {frame_valid, overrun}, 0);
        chk("async_rst_red", RED_ADC_Value, 0);
        p_rdc = '0; p_rpga = '0; p_idc = '0; p_ipga = '0;
        exp_fv = 1'b0; exp_ovr = 1'b0;
        q.delete();
        @(posedge CLK);
        #1 rst = 1'b0;
        chk("post_rst_idle", LED_RED, 0);
        step(1);
        for (int j = 0; j < 8; j++) begin pr[j] = 8'($urandom); pi[j] = 8'($urandom); pd[j] = 8'($urandom); end
        run_frame("f4", 6, -1, -1);

        en0 = 1'b1;
        step(1);
        en0 = 1'b0;
        chk("d0_red_led", l0r, 1);
        n = 0;
        while (!fv0 && n < 100) begin
            step(1);
            n++;
        end
        chk("d0_frame_len", n, 25);
        chk("d0_red", r0, 77);
        chk("d0_ir", i0, 77);
        chk("d0_dark", d0, 0);
        chk("d0_idle", {l0r, l0i, ov0}, 0);
        chk("d0_cfg", {dc0, pga0}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ppg_channel_sequencer.md
Name: ppg_channel_sequencer

Overview:
Time-multiplexes the shared analog front-end (LED drivers, DC compensation DAC, PGA, 8-bit ADC) between RED, IR and an optional ambient/dark phase, using per-channel settings from the calibration controller. Each phase drives the LEDs and applies that channel's DC_Comp and PGA_Gain, waits a settling window, then averages 2^AVG_LOG2 ADC samples. At the end of each frame it publishes RED, IR and DARK averages to the downstream SpO2 datapath through a valid/ready handshake.

Parameters:
SETTLE_CYC, 4, cycles per phase after the LED and gain switch before sampling starts (>=1)
AVG_LOG2, 3, log2 of the number of ADC samples averaged per phase (0..5)
DARK_EN, 1, 1 = include a dark phase (both LEDs off); 0 = skip it

Ports:
CLK  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  run frames continuously while high
cfg_load  in  1  one-cycle strobe that latches the cfg_* inputs into pending registers
cfg_red_dc  in  7  RED DC compensation code
cfg_red_pga  in  4  RED PGA gain code
cfg_ir_dc  in  7  IR DC compensation code
cfg_ir_pga  in  4  IR PGA gain code
ADC  in  8  ADC sample, valid every cycle
LED_RED  out  1  RED LED drive enable
LED_IR  out  1  IR LED drive enable
DC_Comp  out  7  DC compensation code applied to the front-end
PGA_Gain  out  4  PGA gain code applied to the front-end
RED_ADC_Value  out  8  RED phase average
IR_ADC_Value  out  8  IR phase average
DARK_ADC_Value  out  8  dark phase average (0 when DARK_EN=0)
frame_valid  out  1  result triplet is valid
frame_ready  in  1  consumer accepts the result
overrun  out  1  sticky flag: a new frame completed while frame_valid was high and frame_ready was low

Behaviour:
- Single clock, asynchronous active-high reset on CLK.
- Reset values: every output is 0, FSM is IDLE, pending and active configuration are 0.
- All outputs are registered. The front-end controls (LED_*, DC_Comp, PGA_Gain) update on the edge that enters a SETTLE state.
- States: IDLE, RED_SETTLE, RED_ACQ, IR_SETTLE, IR_ACQ, DARK_SETTLE, DARK_ACQ, DONE.
- IDLE: LEDs are off; DC_Comp and PGA_Gain hold their values. When enable=1, go to RED_SETTLE next cycle.
- Entering RED_SETTLE: pending configuration is copied to active. A cfg_load in the same cycle takes effect in the next frame only.
- RED_*: LED_RED=1, LED_IR=0, DC_Comp=red_dc, PGA_Gain=red_pga.
- IR_*: LED_RED=0, LED_IR=1, ir settings.
- DARK_*: both LEDs off, red settings.
- SETTLE lasts exactly SETTLE_CYC cycles; the ADC is ignored during SETTLE.
- ACQ lasts exactly 2^AVG_LOG2 cycles and accumulates ADC every cycle into an unsigned accumulator of width 8+AVG_LOG2, with no overflow possible. The accumulator clears on ACQ entry.
- Phase result = accumulator >> AVG_LOG2 (truncating). It is held in an internal staging register until DONE.
- Order: RED_SETTLE → RED_ACQ → IR_SETTLE → IR_ACQ → (DARK_SETTLE → DARK_ACQ if DARK_EN) → DONE.
- DONE (1 cycle):
  - Staged results load into the *_ADC_Value outputs and frame_valid is set on the exiting edge.
  - If frame_valid was already 1 and frame_ready was 0 in this cycle, overwrite the values and set overrun.
  - Next state: RED_SETTLE if enable=1, else IDLE.
- Handshake: frame_valid stays high and the values stay stable until a cycle with frame_ready=1; frame_valid clears on that edge. If DONE coincides with a ready handshake, the new frame wins and frame_valid stays 1 with no overrun. frame_ready while frame_valid=0 has no effect.
- enable is sampled only in IDLE and DONE. Deasserting it mid-frame completes the current frame.
- overrun clears only on reset or on a cycle with enable=0 in IDLE.
- Frame length (RED_SETTLE entry to DONE inclusive) = (2+DARK_EN)*(SETTLE_CYC+2^AVG_LOG2)+1. With defaults this is 37 cycles.
- Reset asserted mid-frame: immediate return to reset values, with LEDs off asynchronously.

Decomposition:
- Shared package ppg_pkg holds:
  - the state encoding constants (one-hot, 8 bits, matching the calibration controller's encoding style)
  - DC_W=7, PGA_W=4, ADC_W=8
- One sub-module: ppg_phase_accumulator (clear/enable inputs, 8-bit sample input, AVG_LOG2 parameter, truncated average output). It is instantiated once and reused across phases.

Test Plan:
- Defaults, enable=1 at cycle 0, cfg red=(20,5), ir=(40,7), ADC=100/200/20 during RED/IR/DARK ACQ → RED=100, IR=200, DARK=20; frame_valid first high 37 cycles after RED_SETTLE entry; DC_Comp/PGA_Gain sequence 20/5 → 40/7 → 20/5.
- RED ACQ ADC alternating 100,101 over 8 samples (sum 804) → RED_ADC_Value=100 (truncation); all-255 input → 255 (no overflow).
- frame_ready held 0 across two frames → second frame overwrites, overrun=1 stays set; then ready=1 → frame_valid clears next edge, overrun remains 1 until enable=0 in IDLE.
- cfg_load with red_dc=50 during IR_ACQ of frame 1 → frame 1 continues with 20; frame 2 RED_SETTLE drives DC_Comp=50.
- enable dropped mid-RED_ACQ → frame completes, DONE → IDLE, LEDs 0; DARK_EN=0 build → frame 25 cycles, DARK_ADC_Value=0.
- rst pulsed during IR_SETTLE → all outputs 0 immediately, FSM IDLE; with enable=1 after release, RED_SETTLE on the next edge.
